// File: rtl/lbuf_bank_sched.sv
// Bank scheduler for the 3-bank line-buffer SRAM: tracks bank fill state, steers the
// writer, sweeps completed banks for the window datapath and releases them by stride mode.
module lbuf_bank_sched #(
  parameter int AW       = 10,
  parameter int LINE_LEN = 224
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic          frame_start,
  input  logic [3:0]    mode,
  input  logic          wr_bank_done,
  output logic [1:0]    wr_bank,
  output logic          wr_ready,
  input  logic          rd_ready,
  output logic [2:0]    rd_cen,
  output logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_top_bank,
  output logic [1:0]    rd_bot_bank,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [2:0]    bank_full,
  output logic          err_overflow
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_REL} state_t;

  state_t        state_q, state_d;
  logic [2:0]    full_q, full_d;
  logic [1:0]    wr_bank_q, wr_bank_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]    mode_q, mode_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_last_q;

  logic [1:0] top_bank, bot_bank;
  logic       need_one, stride2, wr_ok, issue;
  logic [2:0] rd_mask, rel_mask;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] bank_bit(input logic [1:0] b);
    return 3'b001 << b;
  endfunction

  assign top_bank = rd_ptr_q;
  assign bot_bank = inc3(rd_ptr_q);
  assign need_one = mode_q[3];
  assign stride2  = mode_q[2] & ~mode_q[3];
  assign wr_ok    = ~|(full_q & bank_bit(wr_bank_q)) && (state_q != S_IDLE);
  assign rd_mask  = bank_bit(top_bank) | (need_one ? 3'b000 : bank_bit(bot_bank));
  assign rel_mask = bank_bit(top_bank) | (stride2 ? bank_bit(bot_bank) : 3'b000);
  assign issue    = (state_q == S_READ) && rd_ready;

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_ptr_d  = rd_ptr_q;
    mode_d    = mode_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_WAIT;
          mode_d  = mode;
        end
      end
      S_WAIT: begin
        if (full_q[0] | full_q[1] | full_q[2]) begin
          if (|(full_q & bank_bit(top_bank)) &&
              (need_one || |(full_q & bank_bit(bot_bank)))) begin
            state_d   = S_READ;
            rd_addr_d = '0;
          end
        end
      end
      S_READ: begin
        if (rd_ready) begin
          if (rd_addr_q == LAST_ADDR) state_d = S_REL;
          else                        rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_REL: begin
        full_d   = full_q & ~rel_mask;
        rd_ptr_d = stride2 ? inc3(inc3(rd_ptr_q)) : inc3(rd_ptr_q);
        state_d  = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    // Release and a new fill target different banks, so both updates compose.
    if (wr_bank_done) begin
      if (wr_ok) begin
        full_d    = full_d | bank_bit(wr_bank_q);
        wr_bank_d = inc3(wr_bank_q);
      end else begin
        err_d = 1'b1;
      end
    end

    if (frame_start && (state_q != S_IDLE)) begin
      state_d   = S_WAIT;
      mode_d    = mode;
      full_d    = '0;
      rd_ptr_d  = '0;
      wr_bank_d = '0;
      rd_addr_d = '0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q    <= S_IDLE;
      full_q     <= '0;
      wr_bank_q  <= '0;
      rd_ptr_q   <= '0;
      mode_q     <= '0;
      rd_addr_q  <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      mode_q     <= mode_d;
      rd_addr_q  <= rd_addr_d;
      err_q      <= err_d;
      rd_valid_q <= issue;
      rd_last_q  <= issue && (rd_addr_q == LAST_ADDR);
    end
  end

  assign wr_bank      = wr_bank_q;
  assign wr_ready     = wr_ok;
  assign rd_cen       = issue ? rd_mask : 3'b000;
  assign rd_addr      = rd_addr_q;
  assign rd_top_bank  = top_bank;
  assign rd_bot_bank  = bot_bank;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign bank_full    = full_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_lbuf_bank_sched.sv
// Directed bench for lbuf_bank_sched with LINE_LEN=4: stride modes, backpressure,
// overflow and frame abort.
module tb_lbuf_bank_sched;
  localparam int AW = 4;
  localparam int LL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [3:0]    mode = 4'b0000;
  logic          wr_bank_done = 1'b0;
  logic          rd_ready = 1'b0;
  logic [1:0]    wr_bank, rd_top_bank, rd_bot_bank;
  logic          wr_ready, rd_valid, rd_last, err_overflow;
  logic [2:0]    rd_cen, bank_full;
  logic [AW-1:0] rd_addr;

  int n_chk = 0;
  int n_fail = 0;

  logic [AW-1:0] addr_log [0:15];
  logic [2:0]    cen_log  [0:15];
  int n_iss, n_val, last_at, hold_chk, hold_bad;

  lbuf_bank_sched #(.AW(AW), .LINE_LEN(LL)) dut (
    .SYS_CLK(clk), .SYS_RST(rst), .frame_start(frame_start), .mode(mode),
    .wr_bank_done(wr_bank_done), .wr_bank(wr_bank), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_cen(rd_cen), .rd_addr(rd_addr),
    .rd_top_bank(rd_top_bank), .rd_bot_bank(rd_bot_bank), .rd_valid(rd_valid),
    .rd_last(rd_last), .bank_full(bank_full), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] m);
    mode = m;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      wr_bank_done = 1'b1;
      tick();
      wr_bank_done = 1'b0;
    end
  endtask

  // Records one sweep (issued addresses/enables, valid pulses, address holds), bounded.
  task automatic capture(input bit toggle);
    logic          prev_rdy, prev_cen_nz, pprev_cen_nz;
    logic [AW-1:0] prev_addr;
    bit            done;
    n_iss = 0; n_val = 0; last_at = -1; hold_chk = 0; hold_bad = 0;
    done = 1'b0; prev_rdy = 1'b1; prev_cen_nz = 1'b0; pprev_cen_nz = 1'b0;
    prev_addr = rd_addr;
    for (int it = 0; it < 40 && !done; it++) begin
      tick();
      if (toggle) rd_ready = (it % 2 == 0);
      #1;
      if (!prev_rdy && pprev_cen_nz) begin
        hold_chk++;
        if (rd_addr !== prev_addr) hold_bad++;
      end
      if (rd_cen !== 3'b000 && n_iss < 16) begin
        addr_log[n_iss] = rd_addr;
        cen_log[n_iss]  = rd_cen;
        n_iss++;
      end
      if (rd_valid === 1'b1) begin
        n_val++;
        if (rd_last === 1'b1) last_at = n_val;
      end
      pprev_cen_nz = prev_cen_nz;
      prev_cen_nz  = (rd_cen !== 3'b000);
      prev_rdy     = rd_ready;
      prev_addr    = rd_addr;
      if (rd_last === 1'b1) done = 1'b1;
    end
    if (done) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_chk++; if (rd_cen !== 3'b000) begin n_fail++; $display("FAIL reset_rd_cen: got %b want 000", rd_cen); end
    n_chk++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    n_chk++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_valid_last: got %b%b want 00", rd_valid, rd_last); end
    n_chk++; if (bank_full !== 3'b000) begin n_fail++; $display("FAIL reset_bank_full: got %b want 000", bank_full); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_overflow); end
    n_chk++; if (rd_top_bank !== 2'd0 || rd_bot_bank !== 2'd1) begin n_fail++; $display("FAIL reset_top_bot: got %0d/%0d want 0/1", rd_top_bank, rd_bot_bank); end
    n_chk++; if (wr_bank !== 2'd0) begin n_fail++; $display("FAIL reset_wr_bank: got %0d want 0", wr_bank); end
    rst = 1'b0;
    tick();
    n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL idle_wr_ready: got %b want 0", wr_ready); end
  endtask

  task automatic test_stride1();
    logic [AW-1:0] ea;
    rd_ready = 1'b1;
    start_frame(4'b0010);
    n_chk++; if (wr_ready !== 1'b1 || wr_bank !== 2'd0) begin n_fail++; $display("FAIL s1_wait_wr: got rdy=%b bank=%0d want 1/0", wr_ready, wr_bank); end
    fill(2);
    n_chk++; if (bank_full !== 3'b011) begin n_fail++; $display("FAIL s1_filled: got %b want 011", bank_full); end
    capture(1'b0);
    n_chk++; if (n_iss !== LL) begin n_fail++; $display("FAIL s1_issue_count: got %0d want %0d", n_iss, LL); end
    for (int i = 0; i < LL; i++) begin
      ea = i[AW-1:0];
      n_chk++; if (addr_log[i] !== ea) begin n_fail++; $display("FAIL s1_addr[%0d]: got %0d want %0d", i, addr_log[i], ea); end
    end
    n_chk++; if (cen_log[0] !== 3'b011) begin n_fail++; $display("FAIL s1_cen: got %b want 011", cen_log[0]); end
    n_chk++; if (n_val !== LL || last_at !== LL) begin n_fail++; $display("FAIL s1_valid_last: got %0d/%0d want %0d/%0d", n_val, last_at, LL, LL); end
    n_chk++; if (bank_full !== 3'b010) begin n_fail++; $display("FAIL s1_release: got %b want 010", bank_full); end
    n_chk++; if (rd_top_bank !== 2'd1 || rd_bot_bank !== 2'd2) begin n_fail++; $display("FAIL s1_ptr: got %0d/%0d want 1/2", rd_top_bank, rd_bot_bank); end
    fill(1);
    capture(1'b0);
    n_chk++; if (cen_log[0] !== 3'b110 || n_val !== LL) begin n_fail++; $display("FAIL s1_sweep2: got cen=%b nval=%0d want 110/%0d", cen_log[0], n_val, LL); end
    n_chk++; if (bank_full !== 3'b100) begin n_fail++; $display("FAIL s1_release2: got %b want 100", bank_full); end
    n_chk++; if (wr_bank !== 2'd0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL s1_wr_wrap: got bank=%0d rdy=%b want 0/1", wr_bank, wr_ready); end
  endtask

  task automatic test_stride2();
    rd_ready = 1'b1;
    start_frame(4'b0100);
    fill(2);
    capture(1'b0);
    n_chk++; if (cen_log[0] !== 3'b011 || n_val !== LL) begin n_fail++; $display("FAIL s2_sweep: got cen=%b nval=%0d want 011/%0d", cen_log[0], n_val, LL); end
    n_chk++; if (bank_full !== 3'b000) begin n_fail++; $display("FAIL s2_release: got %b want 000", bank_full); end
    n_chk++; if (rd_top_bank !== 2'd2 || rd_bot_bank !== 2'd0) begin n_fail++; $display("FAIL s2_ptr: got %0d/%0d want 2/0", rd_top_bank, rd_bot_bank); end
    fill(2);
    n_chk++; if (bank_full !== 3'b101) begin n_fail++; $display("FAIL s2_filled2: got %b want 101", bank_full); end
    capture(1'b0);
    n_chk++; if (cen_log[0] !== 3'b101) begin n_fail++; $display("FAIL s2_cen2: got %b want 101", cen_log[0]); end
    n_chk++; if (rd_top_bank !== 2'd1 || bank_full !== 3'b000) begin n_fail++; $display("FAIL s2_ptr2: got top=%0d full=%b want 1/000", rd_top_bank, bank_full); end
  endtask

  task automatic test_fc();
    rd_ready = 1'b1;
    start_frame(4'b1000);
    fill(1);
    capture(1'b0);
    n_chk++; if (cen_log[0] !== 3'b001 || n_iss !== LL) begin n_fail++; $display("FAIL fc_sweep: got cen=%b n=%0d want 001/%0d", cen_log[0], n_iss, LL); end
    n_chk++; if (n_val !== LL || last_at !== LL) begin n_fail++; $display("FAIL fc_valid_last: got %0d/%0d want %0d/%0d", n_val, last_at, LL, LL); end
    n_chk++; if (bank_full !== 3'b000 || rd_top_bank !== 2'd1) begin n_fail++; $display("FAIL fc_release: got full=%b top=%0d want 000/1", bank_full, rd_top_bank); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] ea;
    rd_ready = 1'b1;
    start_frame(4'b0010);
    fill(2);
    capture(1'b1);
    rd_ready = 1'b1;
    for (int i = 0; i < LL; i++) begin
      ea = i[AW-1:0];
      n_chk++; if (addr_log[i] !== ea) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, addr_log[i], ea); end
    end
    n_chk++; if (n_iss !== LL || n_val !== LL || last_at !== LL) begin n_fail++; $display("FAIL bp_counts: got iss=%0d val=%0d last=%0d want %0d", n_iss, n_val, last_at, LL); end
    n_chk++; if (hold_chk !== 3 || hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold: got checks=%0d bad=%0d want 3/0", hold_chk, hold_bad); end
  endtask

  task automatic test_overflow();
    rd_ready = 1'b0;
    start_frame(4'b0010);
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ov_pre_err: got %b want 0", err_overflow); end
    fill(3);
    n_chk++; if (wr_ready !== 1'b0 || bank_full !== 3'b111) begin n_fail++; $display("FAIL ov_full: got rdy=%b full=%b want 0/111", wr_ready, bank_full); end
    wr_bank_done = 1'b1;
    tick();
    wr_bank_done = 1'b0;
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ov_err: got %b want 1", err_overflow); end
    n_chk++; if (bank_full !== 3'b111 || wr_bank !== 2'd0) begin n_fail++; $display("FAIL ov_state: got full=%b bank=%0d want 111/0", bank_full, wr_bank); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ov_no_read: got %b want 0", rd_valid); end
  endtask

  task automatic test_abort();
    start_frame(4'b0010);
    rd_ready = 1'b1;
    n_chk++; if (err_overflow !== 1'b1 || bank_full !== 3'b000) begin n_fail++; $display("FAIL ab_restart: got err=%b full=%b want 1/000", err_overflow, bank_full); end
    fill(2);
    repeat (3) tick();
    n_chk++; if (rd_addr !== 4'd2 || rd_cen !== 3'b011) begin n_fail++; $display("FAIL ab_mid_read: got addr=%0d cen=%b want 2/011", rd_addr, rd_cen); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_chk++; if (rd_cen !== 3'b000 || bank_full !== 3'b000 || wr_bank !== 2'd0) begin n_fail++; $display("FAIL ab_clear: got cen=%b full=%b bank=%0d want 000/000/0", rd_cen, bank_full, wr_bank); end
    n_chk++; if (rd_valid !== 1'b1 || rd_last !== 1'b0) begin n_fail++; $display("FAIL ab_inflight: got valid=%b last=%b want 1/0", rd_valid, rd_last); end
    n_chk++; if (wr_ready !== 1'b1 || err_overflow !== 1'b1) begin n_fail++; $display("FAIL ab_wait: got rdy=%b err=%b want 1/1", wr_ready, err_overflow); end
    tick();
    n_chk++; if (rd_valid !== 1'b0 || rd_cen !== 3'b000) begin n_fail++; $display("FAIL ab_quiet: got valid=%b cen=%b want 0/000", rd_valid, rd_cen); end
    fill(2);
    n_chk++; if (rd_top_bank !== 2'd0 || rd_bot_bank !== 2'd1) begin n_fail++; $display("FAIL ab_ptr: got %0d/%0d want 0/1", rd_top_bank, rd_bot_bank); end
    capture(1'b0);
    n_chk++; if (cen_log[0] !== 3'b011 || n_val !== LL) begin n_fail++; $display("FAIL ab_resweep: got cen=%b nval=%0d want 011/%0d", cen_log[0], n_val, LL); end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_fc();
    test_backpressure();
    test_overflow();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
